// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access controller: data width,
// access-size encodings and the controller state encoding.
// Imported by mem_access_unit and its byte-lane datapath.
package mem_access_unit_pkg;

  localparam int WORD_LEN = 32;

  // mem_size encodings; 2'b11 is handled as a word everywhere.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RMW  = 1'b1
  } state_t;

  // Big-endian lane shift: byte offset k lives at bits 31-8k:24-8k, so the
  // lane sits (3-k)*8 bits above bit 0; a half at offset 0 sits 16 bits up.
  function automatic logic [4:0] lane_shift(input logic [1:0] size,
                                            input logic [1:0] offset);
    logic [4:0] sh;
    sh = 5'd0;
    if (size == SIZE_BYTE)      sh = {~offset, 3'b000};
    else if (size == SIZE_HALF) sh = {~offset[1], 4'b0000};
    return sh;
  endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane_mux.sv
// Purpose : big-endian byte/half/word lane datapath. Extracts and sign/zero
//           extends the addressed lane of a read word (load path) and merges
//           a right-justified store operand into that lane (store path).
// Latency : purely combinational. Backpressure: none, no state.
// Ports   : i_size/i_offset/i_unsigned select the lane; i_rd_word is the
//           memory word; i_st_data the store operand; o_ld_data the extended
//           load value; o_merged the read word with the lane replaced.
module mem_access_unit_byte_lane_mux
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]          i_size,
  input  logic [1:0]          i_offset,
  input  logic                i_unsigned,
  input  logic [WORD_LEN-1:0] i_rd_word,
  input  logic [WORD_LEN-1:0] i_st_data,
  output logic [WORD_LEN-1:0] o_ld_data,
  output logic [WORD_LEN-1:0] o_merged
);

  logic [4:0]          w_shift;
  logic [WORD_LEN-1:0] w_lane;
  logic [WORD_LEN-1:0] w_mask;

  always_comb begin
    w_shift   = lane_shift(i_size, i_offset);
    w_lane    = i_rd_word >> w_shift;
    w_mask    = '1;
    o_ld_data = i_rd_word;

    case (i_size)
      SIZE_BYTE: begin
        w_mask    = {{(WORD_LEN-8){1'b0}}, 8'hFF} << w_shift;
        o_ld_data = {{(WORD_LEN-8){~i_unsigned & w_lane[7]}}, w_lane[7:0]};
      end
      SIZE_HALF: begin
        w_mask    = {{(WORD_LEN-16){1'b0}}, 16'hFFFF} << w_shift;
        o_ld_data = {{(WORD_LEN-16){~i_unsigned & w_lane[15]}}, w_lane[15:0]};
      end
      default: begin
        // Word (and the 2'b11 alias): whole word, offset ignored.
        w_mask    = '1;
        o_ld_data = i_rd_word;
      end
    endcase

    o_merged = (i_rd_word & ~w_mask) | ((i_st_data << w_shift) & w_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose : MEM-stage load/store controller in front of a word-wide data
//           memory; sub-word stores run as read-modify-write, big-endian lanes.
// Latency : loads 1 cycle (load_valid at N+1); word store written end of N;
//           sub-word store stalls cycle N, memory written end of N+1.
// Backpressure: stall freezes upstream for the read half of a sub-word store.
// Config  : define MISALIGN_TRAP_EN to trap misaligned half/word accesses
//           (misalign_err pulse, access suppressed); otherwise low address
//           bits are ignored and misalign_err is tied 0.
// Ports   : clk, rst (async, active-low); EX/MEM request (mem_req, mem_read,
//           mem_write, mem_size, mem_unsigned, address, store_data); data
//           memory port (dm_address, dm_dataIn, dm_writeEn, dm_readEn,
//           dm_dataOut); results (load_data, load_valid, stall, misalign_err).
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_req,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [1:0]          mem_size,
  input  logic                mem_unsigned,
  input  logic [WORD_LEN-1:0] address,
  input  logic [WORD_LEN-1:0] store_data,
  output logic [WORD_LEN-1:0] dm_address,
  output logic [WORD_LEN-1:0] dm_dataIn,
  output logic                dm_writeEn,
  output logic                dm_readEn,
  input  logic [WORD_LEN-1:0] dm_dataOut,
  output logic [WORD_LEN-1:0] load_data,
  output logic                load_valid,
  output logic                stall,
  output logic                misalign_err
);

  state_t              r_state;
  state_t              w_next_state;
  logic [WORD_LEN-1:0] r_merge;
  logic [WORD_LEN-1:2] r_addr;
  logic [WORD_LEN-1:0] r_load_data;
  logic                r_load_valid;

  logic                w_is_sub;
  logic                w_misalign;
  logic                w_store_req;
  logic                w_load_req;
  logic                w_capture_merge;
  logic                w_load_fire;
  logic [WORD_LEN-1:0] w_lane_ld;
  logic [WORD_LEN-1:0] w_lane_merged;

  assign w_is_sub = (mem_size == SIZE_BYTE) || (mem_size == SIZE_HALF);

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((mem_size == SIZE_HALF) && address[0]) ||
                      (mem_size[1] && (address[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Write wins when both read and write are requested.
  assign w_store_req = mem_req & mem_write & ~w_misalign;
  assign w_load_req  = mem_req & mem_read & ~mem_write & ~w_misalign;

  assign w_capture_merge = (r_state == ST_IDLE) && w_store_req && w_is_sub;
  assign w_load_fire     = (r_state == ST_IDLE) && w_load_req;

  mem_access_unit_byte_lane_mux u_byte_lane_mux (
    .i_size     (mem_size),
    .i_offset   (address[1:0]),
    .i_unsigned (mem_unsigned),
    .i_rd_word  (dm_dataOut),
    .i_st_data  (store_data),
    .o_ld_data  (w_lane_ld),
    .o_merged   (w_lane_merged)
  );

  // Next state and memory-port drive.
  always_comb begin
    w_next_state = r_state;
    dm_address   = '0;
    dm_dataIn    = '0;
    dm_writeEn   = 1'b0;
    dm_readEn    = 1'b0;
    stall        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (mem_req) begin
          dm_address = {address[WORD_LEN-1:2], 2'b00};
        end
        if (w_store_req) begin
          if (w_is_sub) begin
            // Read half of the RMW; upstream holds the request meanwhile.
            dm_readEn    = 1'b1;
            stall        = 1'b1;
            w_next_state = ST_RMW;
          end else begin
            dm_writeEn = 1'b1;
            dm_dataIn  = store_data;
          end
        end else if (w_load_req) begin
          dm_readEn = 1'b1;
        end
      end
      ST_RMW: begin
        // Inputs still show the same store here, but the held copy is used
        // so the write does not depend on upstream staying frozen.
        dm_address   = {r_addr, 2'b00};
        dm_dataIn    = r_merge;
        dm_writeEn   = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_merge <= '0;
      r_addr  <= '0;
    end else if (w_capture_merge) begin
      r_merge <= w_lane_merged;
      r_addr  <= address[WORD_LEN-1:2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
    end else begin
      r_load_valid <= w_load_fire;
      if (w_load_fire) begin
        r_load_data <= w_lane_ld;
      end
    end
  end

  assign load_data  = r_load_data;
  assign load_valid = r_load_valid;

`ifdef MISALIGN_TRAP_EN
  logic r_misalign_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_misalign_err <= 1'b0;
    end else begin
      r_misalign_err <= (r_state == ST_IDLE) && mem_req &&
                        (mem_read || mem_write) && w_misalign;
    end
  end

  assign misalign_err = r_misalign_err;
`else
  assign misalign_err = 1'b0;
`endif

endmodule
